// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator encodings and FSM states shared by the calculator sequencer.
package calc_pkg;
    localparam int DW = 6;
    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_CLR = 4'd14;
    localparam logic [3:0] KEY_NEG = 4'd15;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER_A = 3'd1,
        S_ENTER_B = 3'd2,
        S_EXEC    = 3'd3,
        S_RESULT  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;
    function automatic logic is_digit(input logic [3:0] k);
        return k < 4'd10;
    endfunction
    function automatic logic is_op(input logic [3:0] k);
        return k == KEY_ADD || k == KEY_SUB || k == KEY_MUL;
    endfunction
    function automatic logic [1:0] key_op(input logic [3:0] k);
        return (k == KEY_ADD) ? OP_ADD : (k == KEY_SUB) ? OP_SUB : OP_MUL;
    endfunction
endpackage

// File: rtl/calc_digit_accum.sv
// calc_digit_accum: decimal operand entry (magnitude, sign, digit count) with range check.
module calc_digit_accum
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic          digit_en,
    input  logic          neg_en,
    input  logic [3:0]    digit,
    output logic [DW-1:0] value,
    output logic          has_digits,
    output logic          out_of_range
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    logic [DW-1:0] mag_q, mag_d;
    logic          neg_q, neg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    next_mag;
    always_comb begin
        next_mag = 10'(mag_q) * 10'd10 + 10'(digit);
        mag_d = mag_q;
        neg_d = neg_q;
        cnt_d = cnt_q;
        if (clr) begin
            mag_d = '0;
            neg_d = 1'b0;
            cnt_d = '0;
        end else if (load) begin
            mag_d = {2'b00, digit};
            neg_d = 1'b0;
            cnt_d = CW'(1);
        end else if (digit_en && cnt_q < CW'(MAX_DIGITS)) begin
            // saturate so an oversized entry can never wrap back into range
            mag_d = (next_mag > 10'd63) ? 6'd63 : next_mag[DW-1:0];
            cnt_d = cnt_q + CW'(1);
        end else if (neg_en && cnt_q != '0) begin
            neg_d = !neg_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            mag_q <= mag_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
        end
    end
    assign value        = neg_q ? -mag_q : mag_q;
    assign has_digits   = cnt_q != '0;
    assign out_of_range = mag_q > 6'd32 || (mag_q == 6'd32 && !neg_q);
endmodule

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad FSM that builds two operands, issues one operation and displays the result.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    output logic [DW-1:0] ain,
    output logic [DW-1:0] bin,
    output logic [1:0]    op_sel,
    output logic          op_valid,
    input  logic [DW-1:0] res_in,
    input  logic          ovf_in,
    output logic [DW-1:0] disp_value,
    output logic          disp_err,
    output logic [2:0]    state_out
);
    state_t        state_q, state_d;
    logic [DW-1:0] ain_q, ain_d, bin_q, bin_d, res_q, res_d;
    logic [1:0]    op_q, op_d;
    logic          kv, dig, opk, eq, clr, neg;
    logic          a_clr, a_load, a_dig, a_neg, b_clr, b_dig, b_neg;
    logic [DW-1:0] a_value, b_value;
    logic          a_has, b_has, a_oor, b_oor;
    calc_digit_accum #(.MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .digit_en(a_dig),
        .neg_en(a_neg), .digit(key_code), .value(a_value), .has_digits(a_has),
        .out_of_range(a_oor)
    );
    calc_digit_accum #(.MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(1'b0), .digit_en(b_dig),
        .neg_en(b_neg), .digit(key_code), .value(b_value), .has_digits(b_has),
        .out_of_range(b_oor)
    );
    always_comb begin
        kv      = key_valid && state_q != S_EXEC;
        dig     = kv && is_digit(key_code);
        opk     = kv && is_op(key_code);
        eq      = kv && key_code == KEY_EQ;
        clr     = kv && key_code == KEY_CLR;
        neg     = kv && key_code == KEY_NEG;
        state_d = state_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        op_d    = op_q;
        res_d   = res_q;
        a_clr   = 1'b0;
        a_load  = 1'b0;
        a_dig   = 1'b0;
        a_neg   = 1'b0;
        b_clr   = 1'b0;
        b_dig   = 1'b0;
        b_neg   = 1'b0;
        if (clr) begin
            state_d = S_IDLE;
            ain_d   = '0;
            bin_d   = '0;
            op_d    = OP_ADD;
            res_d   = '0;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (dig) begin
                    a_load  = 1'b1;
                    state_d = S_ENTER_A;
                end
                S_ENTER_A: begin
                    a_dig = dig;
                    a_neg = neg;
                    if ((opk || eq) && a_oor) state_d = S_ERROR;
                    else if (opk && a_has) begin
                        op_d    = key_op(key_code);
                        ain_d   = a_value;
                        b_clr   = 1'b1;
                        state_d = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    b_dig = dig;
                    b_neg = neg;
                    if ((opk || eq) && b_oor) state_d = S_ERROR;
                    else if (!b_has && opk) op_d = key_op(key_code);
                    else if (b_has && eq) begin
                        bin_d   = b_value;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_d   = res_in;
                    state_d = ovf_in ? S_ERROR : S_RESULT;
                end
                S_RESULT: if (dig) begin
                    a_load  = 1'b1;
                    b_clr   = 1'b1;
                    state_d = S_ENTER_A;
                end else if (opk) begin
                    ain_d   = res_q;
                    op_d    = key_op(key_code);
                    b_clr   = 1'b1;
                    state_d = S_ENTER_B;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ain_q   <= '0;
            bin_q   <= '0;
            op_q    <= OP_ADD;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end
    assign ain        = ain_q;
    assign bin        = bin_q;
    assign op_sel     = op_q;
    assign op_valid   = state_q == S_EXEC;
    assign disp_err   = state_q == S_ERROR;
    assign state_out  = state_q;
    assign disp_value = (state_q == S_ENTER_A) ? a_value :
                        (state_q == S_ENTER_B || state_q == S_EXEC) ? b_value :
                        (state_q == S_RESULT || state_q == S_ERROR) ? res_q : '0;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: directed key sequences with queued expectations checked by a negedge monitor.
module tb_calc_key_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, key_valid, ovf_in;
    logic [3:0] key_code;
    logic [5:0] ain, bin, res_in, disp_value;
    logic [1:0] op_sel;
    logic       op_valid, disp_err;
    logic [2:0] state_out;
    calc_key_sequencer #(.MAX_DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .ain(ain), .bin(bin), .op_sel(op_sel), .op_valid(op_valid),
        .res_in(res_in), .ovf_in(ovf_in), .disp_value(disp_value),
        .disp_err(disp_err), .state_out(state_out)
    );
    always #5 clk = ~clk;
    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } chk_t;
    chk_t        chk_q[$];
    logic [13:0] ov_q[$];
    int          total = 0;
    int          passed = 0;
    chk_t        c;
    logic [15:0] act;
    logic [13:0] ov_exp;
    function automatic logic [15:0] sample(input int sel);
        case (sel)
            0: return 16'(state_out);
            1: return 16'(disp_value);
            2: return 16'(disp_err);
            3: return 16'(ain);
            4: return 16'(bin);
            5: return 16'(op_sel);
            6: return 16'(op_valid);
            default: return 16'(ov_q.size());
        endcase
    endfunction
    always @(negedge clk) begin
        if (op_valid) begin
            total++;
            if (ov_q.size() == 0)
                $display("FAIL op_valid_unexpected: got ain=%0d bin=%0d op=%0d, required no op_valid", ain, bin, op_sel);
            else begin
                ov_exp = ov_q.pop_front();
                if ({ain, bin, op_sel} == ov_exp) passed++;
                else $display("FAIL op_valid_operands: got ain=%0d bin=%0d op=%0d, required ain=%0d bin=%0d op=%0d",
                              ain, bin, op_sel, ov_exp[13:8], ov_exp[7:2], ov_exp[1:0]);
            end
        end
        while (chk_q.size() > 0) begin
            c   = chk_q.pop_front();
            act = sample(c.sel);
            total++;
            if (act == c.exp) passed++;
            else $display("FAIL %s: got %0d, required %0d", c.name, act, c.exp);
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask
    task automatic expect_val(input string n, input int sel, input logic [15:0] e);
        chk_t x;
        x.name = n;
        x.sel  = sel;
        x.exp  = e;
        chk_q.push_back(x);
    endtask
    task automatic expect_op(input logic [5:0] a, input logic [5:0] b, input logic [1:0] o);
        ov_q.push_back({a, b, o});
    endtask
    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; res_in = 6'd0; ovf_in = 1'b0;
        repeat (2) tick();
        expect_val("reset_state", 0, 0);
        expect_val("reset_disp", 1, 0);
        expect_val("reset_err", 2, 0);
        expect_val("reset_op_valid", 6, 0);
        expect_val("reset_ain", 3, 0);
        rst_n = 1'b1;
        tick();
        // 7 * -3 = -21
        res_in = 6'd43;
        press(7); press(12); press(3); press(15);
        expect_val("neg_disp", 1, 61);
        expect_op(6'd7, 6'd61, 2'b10);
        press(13);
        expect_val("exec_state", 0, 3);
        tick();
        expect_val("mul_state", 0, 4);
        expect_val("mul_disp", 1, 43);
        press(14);
        expect_val("clr_state", 0, 0);
        // overflow path
        press(3); press(1);
        expect_val("disp_31", 1, 31);
        press(12); press(2);
        ovf_in = 1'b1;
        expect_op(6'd31, 6'd2, 2'b10);
        press(13); tick();
        ovf_in = 1'b0;
        expect_val("ovf_state", 0, 5);
        expect_val("ovf_err", 2, 1);
        press(5);
        expect_val("error_sticky", 0, 5);
        press(14);
        expect_val("clr_err_state", 0, 0);
        expect_val("clr_err_flag", 2, 0);
        expect_val("clr_err_disp", 1, 0);
        // range boundaries
        press(4); press(0); press(10);
        expect_val("range_40", 0, 5);
        press(14);
        press(3); press(2); press(13);
        expect_val("range_pos32", 0, 5);
        press(14);
        press(3); press(2); press(15);
        expect_val("disp_neg32", 1, 32);
        press(11);
        expect_val("neg32_state", 0, 2);
        expect_val("neg32_ain", 3, 32);
        expect_val("neg32_op", 5, 1);
        press(14);
        // chaining 5+3=8, 8*2=16
        res_in = 6'd8;
        press(5); press(10); press(3);
        expect_op(6'd5, 6'd3, 2'b00);
        press(13); tick();
        expect_val("chain_disp8", 1, 8);
        res_in = 6'd16;
        press(12);
        expect_val("chain_state", 0, 2);
        expect_val("chain_ain", 3, 8);
        press(2);
        expect_op(6'd8, 6'd2, 2'b10);
        press(13); tick();
        expect_val("chain_disp16", 1, 16);
        press(9);
        expect_val("result_digit_state", 0, 1);
        expect_val("result_digit_disp", 1, 9);
        press(14);
        // third digit ignored, operator replace, NEG with no digits ignored
        press(1); press(2); press(3);
        expect_val("max_digits", 1, 12);
        press(10); press(11); press(15); press(4);
        expect_val("op_replace", 5, 1);
        expect_val("neg_ignored", 1, 4);
        press(14);
        // key during EXEC is dropped
        res_in = 6'd5;
        press(2); press(10); press(3);
        expect_op(6'd2, 6'd3, 2'b00);
        press(13);
        press(14);
        expect_val("exec_drop_state", 0, 4);
        expect_val("exec_drop_disp", 1, 5);
        press(14);
        // reset during EXEC beats both key and capture
        press(2); press(10); press(3);
        expect_op(6'd2, 6'd3, 2'b00);
        press(13);
        rst_n = 1'b0;
        press(9);
        rst_n = 1'b1;
        expect_val("rst_exec_state", 0, 0);
        expect_val("rst_exec_disp", 1, 0);
        expect_val("rst_exec_err", 2, 0);
        expect_val("rst_exec_ain", 3, 0);
        expect_val("rst_exec_bin", 4, 0);
        expect_val("rst_exec_op", 5, 0);
        expect_val("rst_exec_op_valid", 6, 0);
        press(5);
        expect_val("post_rst_disp", 1, 5);
        repeat (2) tick();
        expect_val("op_valid_pending", 7, 0);
        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
